reset_sequencer: RTL and testbench

//  Consumes the synchronized active-low reset and releases NUM_STAGES sub-block resets one at a time, in index order.

---
 rtl/reset_sequencer_if.sv | 30 +++
 rtl/reset_sequencer.sv | 121 ++++++++++++
 tb/tb_reset_sequencer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/reset_sequencer_if.sv
// Handshake bundle between the reset sequencer and the sub-blocks it releases.
// The master side is the sequencer; the slave side is the set of sub-blocks (or a bench).
interface reset_sequencer_if #(
    parameter int NUM_STAGES = 4
);
    logic                  sw_rst_req;
    logic [NUM_STAGES-1:0] stage_ack;
    logic [NUM_STAGES-1:0] stage_rst_n;
    logic                  all_ready;
    logic                  timeout_err;
    logic [3:0]            fail_stage;

    modport master (
        input  sw_rst_req,
        input  stage_ack,
        output stage_rst_n,
        output all_ready,
        output timeout_err,
        output fail_stage
    );

    modport slave (
        output sw_rst_req,
        output stage_ack,
        input  stage_rst_n,
        input  all_ready,
        input  timeout_err,
        input  fail_stage
    );
endinterface

// File: rtl/reset_sequencer.sv
// Releases NUM_STAGES sub-block resets one at a time, waiting for each stage's ack,
// flagging a stage that never acks, and re-running on a software reset request.
module reset_sequencer #(
    parameter int NUM_STAGES  = 4,
    parameter int STAGE_DELAY = 16,
    parameter int TIMEOUT     = 255,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    reset_sequencer_if.master bus
);
    typedef enum logic [1:0] {DELAY, WAIT_ACK, DONE, ERR} state_t;

    localparam logic [CNT_W-1:0] DLY_END  = CNT_W'(STAGE_DELAY - 1);
    localparam logic [CNT_W-1:0] TMO_END  = CNT_W'(TIMEOUT - 1);
    localparam logic [3:0]       LAST_IDX = 4'(NUM_STAGES - 1);

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [3:0]            idx, idx_nxt;
    logic [NUM_STAGES-1:0] rel, rel_nxt;
    logic                  ready, ready_nxt;
    logic                  terr, terr_nxt;
    logic [3:0]            fs, fs_nxt;
    logic [NUM_STAGES-1:0] sel;
    logic                  ack_cur;

    // Counter never wraps even if a terminal compare were somehow missed.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Only the ack of the stage currently being waited on is ever looked at.
    assign sel     = NUM_STAGES'(1) << idx;
    assign ack_cur = |(bus.stage_ack & sel);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        rel_nxt   = rel;
        ready_nxt = ready;
        terr_nxt  = terr;
        fs_nxt    = fs;
        if (bus.sw_rst_req) begin
            state_nxt = DELAY;
            cnt_nxt   = '0;
            idx_nxt   = '0;
            rel_nxt   = '0;
            ready_nxt = 1'b0;
            terr_nxt  = 1'b0;
        end else begin
            case (state)
                DELAY: begin
                    if (cnt == DLY_END) begin
                        rel_nxt   = rel | sel;
                        cnt_nxt   = '0;
                        state_nxt = WAIT_ACK;
                    end else begin
                        cnt_nxt = sat_inc(cnt);
                    end
                end
                WAIT_ACK: begin
                    // An ack on the final timeout cycle takes precedence over the error.
                    if (ack_cur) begin
                        cnt_nxt = '0;
                        if (idx == LAST_IDX) begin
                            state_nxt = DONE;
                            ready_nxt = 1'b1;
                        end else begin
                            idx_nxt   = idx + 4'd1;
                            state_nxt = DELAY;
                        end
                    end else if (cnt == TMO_END) begin
                        state_nxt = ERR;
                        terr_nxt  = 1'b1;
                        fs_nxt    = idx;
                        rel_nxt   = '0;
                    end else begin
                        cnt_nxt = sat_inc(cnt);
                    end
                end
                DONE: begin
                    ready_nxt = 1'b1;
                end
                ERR: begin
                    rel_nxt = '0;
                end
                default: begin
                    state_nxt = DELAY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= DELAY;
            cnt   <= '0;
            idx   <= '0;
            rel   <= '0;
            ready <= 1'b0;
            terr  <= 1'b0;
            fs    <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            rel   <= rel_nxt;
            ready <= ready_nxt;
            terr  <= terr_nxt;
            fs    <= fs_nxt;
        end
    end

    assign bus.stage_rst_n = rel;
    assign bus.all_ready   = ready;
    assign bus.timeout_err = terr;
    assign bus.fail_stage  = fs;
endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: expected output events are queued with the
// edge number they must appear on, and a negedge monitor pops them as outputs change.
`timescale 1ns/1ps
module tb_reset_sequencer;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    reset_sequencer_if #(.NUM_STAGES(4)) bus();

    reset_sequencer #(
        .NUM_STAGES (4),
        .STAGE_DELAY(16),
        .TIMEOUT    (255),
        .CNT_W      (8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct packed {
        logic [3:0] rst;
        logic       rdy;
        logic       terr;
        logic [3:0] fs;
    } out_t;

    typedef struct {
        int   cyc;
        out_t o;
    } exp_t;

    exp_t q[$];
    out_t cur;
    out_t last;
    bit   mon_en = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   dly[4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic out_t sample();
        return {bus.stage_rst_n, bus.all_ready, bus.timeout_err, bus.fail_stage};
    endfunction

    function automatic void push(input int c, input logic [3:0] r, input logic rdy,
                                 input logic te, input logic [3:0] fs);
        exp_t e;
        e.cyc = c;
        e.o   = {r, rdy, te, fs};
        if (e.o != cur) begin
            q.push_back(e);
            cur = e.o;
        end
    endfunction

    always @(negedge clk) begin
        out_t       s;
        exp_t       e;
        logic [3:0] t;
        if (mon_en) begin
            s = sample();
            if (s !== last) begin
                if (q.size() == 0) begin
                    check("unexpected_event", s, last);
                end else begin
                    e = q.pop_front();
                    check("event_cycle", cyc, e.cyc);
                    check("stage_rst_n", s.rst, e.o.rst);
                    check("all_ready", s.rdy, e.o.rdy);
                    check("timeout_err", s.terr, e.o.terr);
                    check("fail_stage", s.fs, e.o.fs);
                end
                t = s.rst + 4'd1;
                check("monotonic", ((t & s.rst) == 4'd0), 1);
                last = s;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int t);
        while (cyc < t) tick();
    endtask

    task automatic do_rst(input logic [3:0] ackv, output int b);
        tick();
        rst_n          = 1'b0;
        bus.sw_rst_req = 1'b0;
        bus.stage_ack  = ackv;
        push(cyc, 4'h0, 1'b0, 1'b0, 4'h0);
        tick();
        tick();
        rst_n = 1'b1;
        b     = cyc;
    endtask

    task automatic do_sw(input int hold, output int b);
        bus.sw_rst_req = 1'b1;
        bus.stage_ack  = 4'h0;
        push(cyc + 1, 4'h0, 1'b0, 1'b0, cur.fs);
        repeat (hold) tick();
        bus.sw_rst_req = 1'b0;
        b = cyc;
    endtask

    // b is the last edge before counting starts; releases and acks follow dly[].
    task automatic run_seq(input int b);
        int start;
        int rel;
        int a;
        start = b;
        for (int s = 0; s < 4; s++) begin
            rel = start + 16;
            push(rel, 4'((1 << (s + 1)) - 1), 1'b0, 1'b0, cur.fs);
            if (dly[s] > 255) begin
                push(rel + 255, 4'h0, 1'b0, 1'b1, 4'(s));
                goto(rel + dly[s] - 1);
                bus.stage_ack[s] = 1'b1;
                goto(rel + dly[s] + 3);
                return;
            end
            a = rel + dly[s];
            goto(a - 1);
            bus.stage_ack[s] = 1'b1;
            if (s == 3) push(a, 4'hf, 1'b1, 1'b0, cur.fs);
            start = a;
        end
        goto(start + 3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int b;
        bus.sw_rst_req = 1'b0;
        bus.stage_ack  = 4'h0;
        #2 rst_n = 1'b0;
        #1;
        check("reset_stage_rst_n", bus.stage_rst_n, 4'h0);
        check("reset_all_ready", bus.all_ready, 1'b0);
        check("reset_timeout_err", bus.timeout_err, 1'b0);
        check("reset_fail_stage", bus.fail_stage, 4'h0);
        last   = sample();
        cur    = last;
        mon_en = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        b     = cyc;

        // Nominal sequence, ack 3 cycles after each release.
        dly = '{3, 3, 3, 3};
        run_seq(b);

        // Software reset pulse from DONE, then a level request held several cycles.
        do_sw(1, b);
        run_seq(b);
        do_sw(5, b);
        run_seq(b);

        // Stage 2 never acks in time; late ack must not rescue ERR.
        do_rst(4'h0, b);
        dly = '{3, 3, 300, 3};
        run_seq(b);
        check("err_hold_rst", bus.stage_rst_n, 4'h0);

        // Software reset leaves fail_stage; ack exactly on the last timeout cycle wins.
        do_sw(1, b);
        dly = '{3, 3, 255, 3};
        run_seq(b);

        // One cycle later the error is raised.
        do_sw(1, b);
        dly = '{3, 3, 256, 3};
        run_seq(b);

        // Async reset while waiting on stage 1, then a full restart.
        do_rst(4'h0, b);
        push(b + 16, 4'h1, 1'b0, 1'b0, 4'h0);
        goto(b + 18);
        bus.stage_ack[0] = 1'b1;
        push(b + 35, 4'h3, 1'b0, 1'b0, 4'h0);
        goto(b + 37);
        check("pre_async_rst", bus.stage_rst_n, 4'h3);
        rst_n = 1'b0;
        push(cyc, 4'h0, 1'b0, 1'b0, 4'h0);
        #1;
        check("async_stage_rst_n", bus.stage_rst_n, 4'h0);
        check("async_all_ready", bus.all_ready, 1'b0);
        tick();
        bus.stage_ack = 4'h0;
        tick();
        rst_n = 1'b1;
        b     = cyc;
        dly   = '{3, 3, 3, 3};
        run_seq(b);

        // All acks tied high from reset: releases spaced by STAGE_DELAY+1.
        do_rst(4'hf, b);
        dly = '{1, 1, 1, 1};
        run_seq(b);

        tick();
        tick();
        check("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
